// File: rtl/decoder_cntrl_pkg.sv
// Shared definitions for the pdi decoder control: opcodes, header bit positions, FSM states.
package decoder_cntrl_pkg;

   localparam logic [3:0] OP_ENC    = 4'b0010;
   localparam logic [3:0] OP_DEC    = 4'b0011;
   localparam logic [3:0] OP_LDKEY  = 4'b0100;
   localparam logic [3:0] OP_LDSEED = 4'b0101;
   localparam logic [3:0] OP_ENC_KU = 4'b0110;

   localparam int HDR_EOT      = 24;
   localparam int HDR_EOI      = 25;
   localparam int HDR_LAST     = 26;
   localparam int HDR_DTYPE_HI = 31;
   localparam int HDR_DTYPE_LO = 28;
   localparam int HDR_LEN_HI   = 15;
   localparam int HDR_LEN_LO   = 0;

   typedef enum logic [1:0] {
      S_INSTR = 2'd0,
      S_HEAD  = 2'd1,
      S_DATA  = 2'd2
   } state_t;

endpackage

// File: rtl/decoder_cntrl_byte_mask_gen.sv
// Combinational byte-valid mask for the next data word of a segment, MSB = first byte.
// Also reports whether that word is partial and whether it ends the segment.
module byte_mask_gen #(
   parameter int NBYTES = 4
) (
   input  logic [15:0]       remaining,
   output logic [NBYTES-1:0] sel_nibble,
   output logic              partial,
   output logic              last
);

   always_comb begin
      sel_nibble = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if ({16'd0, remaining} > 32'(i)) sel_nibble[NBYTES-1-i] = 1'b1;
      end
      partial = {16'd0, remaining} < 32'(NBYTES);
      last    = {16'd0, remaining} <= 32'(NBYTES);
   end

endmodule

// File: rtl/decoder_cntrl.sv
// Input-side decoder: classifies pdi words as instruction/header/data into a one-word buffer.
// Latency 1 cycle accept-to-valid; data words refill back-to-back, other classes take a bubble.
module decoder_cntrl
   import decoder_cntrl_pkg::*;
#(
   parameter int BUS_SIZE = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BUS_SIZE-1:0]     pdi_data,
   input  logic                    pdi_valid,
   output logic                    pdi_ready,
   output logic                    instruction_valid,
   output logic                    header_valid,
   output logic                    data_in_valid,
   input  logic                    rdy_instr_fetch,
   input  logic                    rdy_head_fetch,
   input  logic                    rdy_data_fetch,
   output logic                    decrypt,
   output logic                    key_update,
   output logic                    key_only,
   output logic                    seed_update,
   output logic [3:0]              dtype,
   output logic                    eot,
   output logic                    eoi,
   output logic [15:0]             length,
   output logic                    seg_empty,
   output logic [BUS_SIZE/8-1:0]   sel_nibble,
   output logic                    data_in_partial,
   output logic                    data_in_last_of_seg,
   output logic [BUS_SIZE-1:0]     dec_data
);

   localparam int BUSdiv8 = BUS_SIZE / 8;

   state_t              state;
   logic                buf_valid;
   logic                last_seg;
   logic [15:0]         remaining;
   logic [15:0]         rem_next;
   logic                consume;
   logic                accept;
   logic [3:0]          opcode;
   logic                instr_ok;
   logic [BUSdiv8-1:0]  mask_sel;
   logic                mask_partial;
   logic                mask_last;
   logic [BUS_SIZE-1:0] masked;

   byte_mask_gen #(.NBYTES(BUSdiv8)) u_mask (
      .remaining  (remaining),
      .sel_nibble (mask_sel),
      .partial    (mask_partial),
      .last       (mask_last)
   );

   assign instruction_valid = buf_valid && (state == S_INSTR);
   assign header_valid      = buf_valid && (state == S_HEAD);
   assign data_in_valid     = buf_valid && (state == S_DATA);

   always_comb begin
      consume = 1'b0;
      case (state)
         S_INSTR: consume = buf_valid && rdy_instr_fetch;
         S_HEAD:  consume = buf_valid && rdy_head_fetch;
         S_DATA:  consume = buf_valid && rdy_data_fetch;
         default: consume = 1'b0;
      endcase
   end

   // Only a non-final data word may be replaced in the same cycle it leaves.
   assign pdi_ready = rst && (!buf_valid ||
                              (state == S_DATA && consume && !data_in_last_of_seg));
   assign accept    = pdi_valid && pdi_ready;

   assign opcode   = pdi_data[BUS_SIZE-1 -: 4];
   assign instr_ok = (opcode == OP_ENC) || (opcode == OP_DEC) || (opcode == OP_LDKEY) ||
                     (opcode == OP_ENC_KU) || (opcode == OP_LDSEED);
   assign rem_next = (remaining > 16'(BUSdiv8)) ? remaining - 16'(BUSdiv8) : 16'd0;

   always_comb begin
      masked = '0;
      for (int i = 0; i < BUSdiv8; i++) begin
         masked[BUS_SIZE-1-8*i -: 8] = mask_sel[BUSdiv8-1-i] ? pdi_data[BUS_SIZE-1-8*i -: 8] : 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state               <= S_INSTR;
         buf_valid           <= 1'b0;
         last_seg            <= 1'b0;
         remaining           <= '0;
         decrypt             <= 1'b0;
         key_update          <= 1'b0;
         key_only            <= 1'b0;
         seed_update         <= 1'b0;
         dtype               <= '0;
         eot                 <= 1'b0;
         eoi                 <= 1'b0;
         length              <= '0;
         seg_empty           <= 1'b0;
         sel_nibble          <= '0;
         data_in_partial     <= 1'b0;
         data_in_last_of_seg <= 1'b0;
         dec_data            <= '0;
      end else begin
         if (consume) begin
            buf_valid <= 1'b0;
            case (state)
               S_INSTR: state <= S_HEAD;
               S_HEAD: begin
                  if (seg_empty) state <= last_seg ? S_INSTR : S_HEAD;
                  else           state <= S_DATA;
               end
               S_DATA: begin
                  if (data_in_last_of_seg) state <= last_seg ? S_INSTR : S_HEAD;
               end
               default: state <= S_INSTR;
            endcase
         end
         if (accept) begin
            case (state)
               S_INSTR: begin
                  // Unknown opcodes are swallowed without raising a valid.
                  if (instr_ok) begin
                     buf_valid   <= 1'b1;
                     decrypt     <= (opcode == OP_DEC);
                     key_update  <= (opcode == OP_LDKEY) || (opcode == OP_ENC_KU);
                     key_only    <= (opcode == OP_LDKEY);
                     seed_update <= (opcode == OP_LDSEED);
                  end
               end
               S_HEAD: begin
                  buf_valid <= 1'b1;
                  dtype     <= pdi_data[HDR_DTYPE_HI:HDR_DTYPE_LO];
                  eot       <= pdi_data[HDR_EOT];
                  eoi       <= pdi_data[HDR_EOI];
                  last_seg  <= pdi_data[HDR_LAST];
                  length    <= pdi_data[HDR_LEN_HI:HDR_LEN_LO];
                  remaining <= pdi_data[HDR_LEN_HI:HDR_LEN_LO];
                  seg_empty <= (pdi_data[HDR_LEN_HI:HDR_LEN_LO] == 16'd0);
               end
               S_DATA: begin
                  // remaining tracks bytes still to be fetched, so a same-cycle refill sees the right count.
                  buf_valid           <= 1'b1;
                  sel_nibble          <= mask_sel;
                  data_in_partial     <= mask_partial;
                  data_in_last_of_seg <= mask_last;
                  dec_data            <= masked;
                  remaining           <= rem_next;
               end
               default: buf_valid <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_decoder_cntrl.sv
// Randomized bench: a stream-grammar model predicts each decoded word; a monitor checks them on consume.
module tb_decoder_cntrl;

   logic        clk;
   logic        rst;
   logic [31:0] pdi_data;
   logic        pdi_valid;
   logic        pdi_ready;
   logic        instruction_valid, header_valid, data_in_valid;
   logic        rdy_instr_fetch, rdy_head_fetch, rdy_data_fetch;
   logic        decrypt, key_update, key_only, seed_update;
   logic [3:0]  dtype;
   logic        eot, eoi;
   logic [15:0] length;
   logic        seg_empty;
   logic [3:0]  sel_nibble;
   logic        data_in_partial, data_in_last_of_seg;
   logic [31:0] dec_data;

   decoder_cntrl #(.BUS_SIZE(32)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .pdi_data            (pdi_data),
      .pdi_valid           (pdi_valid),
      .pdi_ready           (pdi_ready),
      .instruction_valid   (instruction_valid),
      .header_valid        (header_valid),
      .data_in_valid       (data_in_valid),
      .rdy_instr_fetch     (rdy_instr_fetch),
      .rdy_head_fetch      (rdy_head_fetch),
      .rdy_data_fetch      (rdy_data_fetch),
      .decrypt             (decrypt),
      .key_update          (key_update),
      .key_only            (key_only),
      .seed_update         (seed_update),
      .dtype               (dtype),
      .eot                 (eot),
      .eoi                 (eoi),
      .length              (length),
      .seg_empty           (seg_empty),
      .sel_nibble          (sel_nibble),
      .data_in_partial     (data_in_partial),
      .data_in_last_of_seg (data_in_last_of_seg),
      .dec_data            (dec_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;   // 0 instruction, 1 header, 2 data
      logic [3:0]  flags;  // {decrypt, key_update, key_only, seed_update}
      logic [3:0]  dtype;
      logic        eot, eoi;
      logic [15:0] len;
      logic        empty;
      logic [3:0]  sel;
      logic        partial, last;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];
   exp_t m_hdr;
   int   m_mode;      // what the next accepted word means: 0 instr, 1 header, 2 data
   int   m_rem;
   bit   m_lastseg;

   int   n_cmp  = 0;
   int   n_fail = 0;

   logic        cur_v;
   logic [31:0] cur_d;
   int          rdy_mode;   // 0 random, 1 all ready, 2 data consumer stalled
   bit          acc;
   int          steps;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_accept(input logic [31:0] w);
      exp_t e;
      int   nb;
      e = '{default: 0};
      case (m_mode)
         0: begin
            e.kind = 0;
            case (w[31:28])
               4'h2:    e.flags = 4'b0000;
               4'h3:    e.flags = 4'b1000;
               4'h4:    e.flags = 4'b0110;
               4'h6:    e.flags = 4'b0100;
               4'h5:    e.flags = 4'b0001;
               default: e.kind  = -1;
            endcase
            if (e.kind == 0) begin
               q.push_back(e);
               m_mode = 1;
            end
         end
         1: begin
            e.kind  = 1;
            e.dtype = w[31:28];
            e.eot   = w[24];
            e.eoi   = w[25];
            e.len   = w[15:0];
            e.empty = (w[15:0] == 16'd0);
            q.push_back(e);
            m_hdr     = e;
            m_lastseg = w[26];
            m_rem     = int'(w[15:0]);
            if (m_rem == 0) m_mode = m_lastseg ? 0 : 1;
            else            m_mode = 2;
         end
         default: begin
            nb     = (m_rem < 4) ? m_rem : 4;
            e      = m_hdr;
            e.kind = 2;
            e.sel  = '0;
            e.data = '0;
            for (int b = 0; b < nb; b++) begin
               e.sel[3-b]         = 1'b1;
               e.data[31-8*b -: 8] = w[31-8*b -: 8];
            end
            e.partial = (nb < 4);
            m_rem     = m_rem - nb;
            e.last    = (m_rem == 0);
            q.push_back(e);
            if (m_rem == 0) m_mode = m_lastseg ? 0 : 1;
         end
      endcase
   endtask

   task automatic step();
      bit exp_ready;
      @(negedge clk);
      pdi_valid = cur_v;
      pdi_data  = cur_v ? cur_d : $urandom;
      case (rdy_mode)
         1: begin
            rdy_instr_fetch = 1'b1; rdy_head_fetch = 1'b1; rdy_data_fetch = 1'b1;
         end
         2: begin
            rdy_instr_fetch = 1'b1; rdy_head_fetch = 1'b1; rdy_data_fetch = 1'b0;
         end
         default: begin
            rdy_instr_fetch = ($urandom_range(0, 3) != 0);
            rdy_head_fetch  = ($urandom_range(0, 3) != 0);
            rdy_data_fetch  = ($urandom_range(0, 3) != 0);
         end
      endcase
      #1;
      exp_ready = (q.size() == 0) || (q[0].kind == 2 && rdy_data_fetch && !q[0].last);
      check("pdi_ready", 64'(pdi_ready), 64'(exp_ready));
      acc = pdi_valid && pdi_ready;
      if (acc) model_accept(pdi_data);
   endtask

   task automatic send(input logic [31:0] w);
      cur_v = 1'b1;
      cur_d = w;
      acc   = 1'b0;
      steps = 0;
      for (int i = 0; i < 200 && !acc; i++) begin
         step();
         steps++;
      end
      check("accept_within_budget", 64'(acc), 64'd1);
      cur_v = 1'b0;
   endtask

   task automatic idle(input int k);
      cur_v = 1'b0;
      for (int i = 0; i < k; i++) step();
   endtask

   // Monitor: compare on every consume, and check held outputs stay frozen while unconsumed.
   initial begin
      logic [63:0] snap, prev_snap;
      logic [31:0] prev_data;
      bit          have_prev;
      bit          ci, ch, cd;
      int          nv;
      exp_t        e;
      have_prev = 0;
      prev_snap = '0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            have_prev = 0;
         end else begin
            nv = int'(instruction_valid) + int'(header_valid) + int'(data_in_valid);
            check("one_valid_at_most", 64'(nv <= 1), 64'd1);
            snap = {28'd0, instruction_valid, header_valid, data_in_valid,
                    decrypt, key_update, key_only, seed_update, dtype, eot, eoi,
                    length, seg_empty, sel_nibble, data_in_partial, data_in_last_of_seg};
            if (have_prev) begin
               check("held_fields_stable", snap, prev_snap);
               check("held_data_stable", 64'(dec_data), 64'(prev_data));
            end
            ci = instruction_valid && rdy_instr_fetch;
            ch = header_valid && rdy_head_fetch;
            cd = data_in_valid && rdy_data_fetch;
            if (ci || ch || cd) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_output: valid with nothing predicted (t=%0t)", $time);
               end else begin
                  e = q.pop_front();
                  check("word_class", 64'(ci ? 0 : (ch ? 1 : 2)), 64'(e.kind));
                  if (ci) begin
                     check("instr_flags", 64'({decrypt, key_update, key_only, seed_update}), 64'(e.flags));
                  end else if (ch) begin
                     check("hdr_dtype", 64'(dtype), 64'(e.dtype));
                     check("hdr_eot_eoi", 64'({eot, eoi}), 64'({e.eot, e.eoi}));
                     check("hdr_length", 64'(length), 64'(e.len));
                     check("hdr_seg_empty", 64'(seg_empty), 64'(e.empty));
                  end else begin
                     check("data_sel_nibble", 64'(sel_nibble), 64'(e.sel));
                     check("data_partial", 64'(data_in_partial), 64'(e.partial));
                     check("data_last", 64'(data_in_last_of_seg), 64'(e.last));
                     check("data_value", 64'(dec_data), 64'(e.data));
                     check("data_hdr_length", 64'(length), 64'(e.len));
                  end
               end
            end
            have_prev = (nv != 0) && !(ci || ch || cd);
            prev_snap = snap;
            prev_data = dec_data;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] hdr;
      int          len, nseg;
      rst = 1'b0;
      pdi_valid = 1'b0; pdi_data = '0;
      rdy_instr_fetch = 1'b0; rdy_head_fetch = 1'b0; rdy_data_fetch = 1'b0;
      cur_v = 1'b0; cur_d = '0; rdy_mode = 1;
      m_mode = 0; m_rem = 0; m_lastseg = 0; m_hdr = '{default: 0};

      @(negedge clk); #1;
      check("reset_valids", 64'({instruction_valid, header_valid, data_in_valid}), 64'd0);
      check("reset_pdi_ready", 64'(pdi_ready), 64'd0);
      check("reset_fields", 64'({decrypt, key_update, key_only, seed_update, dtype, eot, eoi,
                                 length, seg_empty, sel_nibble, data_in_partial, data_in_last_of_seg}), 64'd0);
      check("reset_dec_data", 64'(dec_data), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // ENC, then an 11-byte final segment: masks F,F,E.
      send(32'h2000_0000);
      send(32'h5600_000B);
      for (int i = 0; i < 3; i++) send($urandom);
      // LDKEY, empty non-final header, then a 4-byte final segment.
      send(32'h4000_0000);
      send(32'h1000_0000);
      send(32'h0400_0004);
      send($urandom);

      // Consumer stalls for 5 cycles, then 24-byte segment streams at full rate.
      send(32'h6000_0000);
      send(32'h0400_0018);
      rdy_mode = 2;
      send($urandom);
      cur_v = 1'b1;
      cur_d = $urandom;
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_no_accept", 64'(acc), 64'd0);
      end
      rdy_mode = 1;
      for (int i = 0; i < 5; i++) begin
         send(i == 0 ? cur_d : $urandom);
         check("stream_one_per_cycle", 64'(steps), 64'd1);
      end

      // Unknown opcode is dropped; the following DEC is decoded as an instruction.
      send(32'hF000_0000);
      send(32'h3000_0000);
      send(32'h0400_0005);
      rdy_mode = 0;
      send($urandom);
      send($urandom);
      rdy_mode = 1;
      idle(3);

      // Asynchronous reset with 8 bytes of a segment still outstanding.
      send(32'h2000_0000);
      send(32'h0400_000C);
      rdy_mode = 2;
      send($urandom);
      #3;
      rst = 1'b0;
      #1;
      check("async_reset_valids", 64'({instruction_valid, header_valid, data_in_valid}), 64'd0);
      check("async_reset_pdi_ready", 64'(pdi_ready), 64'd0);
      check("async_reset_data", 64'(dec_data), 64'd0);
      q.delete();
      m_mode = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      rdy_mode = 1;
      send(32'h3000_0000);
      send(32'h0400_0000);
      idle(2);

      // Random programs with random consumer readiness and input gaps.
      rdy_mode = 0;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 4) == 0)
            send({4'($urandom_range(7, 15)), 28'($urandom)});
         send({4'($urandom_range(2, 6)), 28'($urandom)});
         nseg = $urandom_range(1, 3);
         for (int s = 0; s < nseg; s++) begin
            len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 17);
            hdr = {4'($urandom), 1'($urandom), (s == nseg - 1) ? 1'b1 : 1'b0,
                   1'($urandom), 1'($urandom), 8'($urandom), 16'(len)};
            send(hdr);
            for (int w = 0; w < (len + 3) / 4; w++) begin
               send($urandom);
               if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
         end
      end

      rdy_mode = 1;
      idle(10);
      check("queue_drained", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
